// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: oversampled UART receiver with parity/stop checking; define UART_RX_BREAK_DET_EN to enable break detection
module uart_rx_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [PRESCALE_W-1:0] Prescale,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  STOP2,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err,
  output logic                  brk_det
);
  localparam int BW = $clog2(DATA_WIDTH);
`ifdef UART_RX_BREAK_DET_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, VALID, BRK_WAIT} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, VALID} state_t;
`endif
  state_t state;
  logic [PRESCALE_W-1:0] edge_cnt, half, mid_lo, mid_hi, last;
  logic [BW-1:0] bit_cnt;
  logic [DATA_WIDTH-1:0] shreg;
  logic par_flag, stp_flag, samp_a, samp_b, cfg_par, cfg_typ, cfg_stop2;
  logic bit_end, sample_pt, bit_val;
  assign half = {1'b0, Prescale[PRESCALE_W-1:1]};
  assign mid_lo = half - PRESCALE_W'(1);
  assign mid_hi = half + PRESCALE_W'(1);
  assign last = Prescale - PRESCALE_W'(1);
  assign bit_end = edge_cnt == last;
  assign sample_pt = edge_cnt == mid_hi;
  assign bit_val = (samp_a & samp_b) | (samp_a & RX_IN) | (samp_b & RX_IN);
`ifdef UART_RX_BREAK_DET_EN
  logic any_one;
  always_ff @(posedge CLK or negedge RST)
    if (!RST) any_one <= 1'b0;
    else any_one <= (state == DATA || state == PARITY || state == STOP) ? any_one | (sample_pt & bit_val) : 1'b0;
`endif
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= IDLE;
      edge_cnt <= '0;
      bit_cnt <= '0;
      shreg <= '0;
      par_flag <= 1'b0;
      stp_flag <= 1'b0;
      samp_a <= 1'b0;
      samp_b <= 1'b0;
      cfg_par <= 1'b0;
      cfg_typ <= 1'b0;
      cfg_stop2 <= 1'b0;
      P_DATA <= '0;
      data_valid <= 1'b0;
      par_err <= 1'b0;
      stp_err <= 1'b0;
      brk_det <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      brk_det <= 1'b0;
      edge_cnt <= bit_end ? '0 : edge_cnt + PRESCALE_W'(1);
      if (edge_cnt == mid_lo) samp_a <= RX_IN;
      if (edge_cnt == half) samp_b <= RX_IN;
      case (state)
        IDLE: begin
          edge_cnt <= '0;
          if (!RX_IN) begin
            state <= START;
            {cfg_par, cfg_typ, cfg_stop2} <= {PAR_EN, PAR_TYP, STOP2};
            {par_flag, stp_flag} <= 2'b00;
          end
        end
        START: begin
          if (sample_pt && bit_val) begin
            state <= IDLE;
            edge_cnt <= '0;
          end else if (bit_end) begin
            state <= DATA;
            bit_cnt <= '0;
          end
        end
        DATA: begin
          if (sample_pt) shreg <= {bit_val, shreg[DATA_WIDTH-1:1]};
          if (bit_end) begin
            bit_cnt <= bit_cnt + BW'(1);
            if (bit_cnt == BW'(DATA_WIDTH - 1)) begin
              bit_cnt <= '0;
              state <= cfg_par ? PARITY : STOP;
            end
          end
        end
        PARITY: begin
          if (sample_pt) par_flag <= bit_val != (^shreg ^ cfg_typ);
          if (bit_end) state <= STOP;
        end
        STOP: begin
          if (sample_pt && !bit_val) stp_flag <= 1'b1;
          if (bit_end) begin
            bit_cnt <= (cfg_stop2 && bit_cnt == '0) ? BW'(1) : '0;
            if (!(cfg_stop2 && bit_cnt == '0)) state <= VALID;
          end
        end
        VALID: begin
          par_err <= par_flag;
          stp_err <= stp_flag;
`ifdef UART_RX_BREAK_DET_EN
          if (!any_one) begin
            brk_det <= 1'b1;
            stp_err <= 1'b1;
            state <= BRK_WAIT;
            edge_cnt <= '0;
          end else
`endif
          begin
            if (!par_flag && !stp_flag) begin
              P_DATA <= shreg;
              data_valid <= 1'b1;
            end
            // a start bit seen here has already lasted one cycle, so resume the count at 1
            if (!RX_IN) begin
              state <= START;
              edge_cnt <= PRESCALE_W'(1);
              {cfg_par, cfg_typ, cfg_stop2} <= {PAR_EN, PAR_TYP, STOP2};
              {par_flag, stp_flag} <= 2'b00;
            end else begin
              state <= IDLE;
              edge_cnt <= '0;
            end
          end
        end
`ifdef UART_RX_BREAK_DET_EN
        BRK_WAIT: begin
          edge_cnt <= '0;
          if (RX_IN) state <= IDLE;
        end
`endif
        default: begin
          state <= IDLE;
          edge_cnt <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: directed scenarios for uart_rx_ctrl at DATA_WIDTH 8
module tb_uart_rx_ctrl;
  logic CLK = 1'b0, RST = 1'b0, RX_IN = 1'b1;
  logic [5:0] Prescale = 6'd8;
  logic PAR_EN = 1'b0, PAR_TYP = 1'b0, STOP2 = 1'b0;
  logic [7:0] P_DATA;
  logic data_valid, par_err, stp_err, brk_det;
  int tests = 0, fails = 0, cyc = 0, dv_cnt = 0, brk_cnt = 0, start_cyc = 0;
  int dv_cyc[4];
  logic [7:0] dv_data[4];
`ifdef UART_RX_BREAK_DET_EN
  localparam int BRK_EXP = 1;
`else
  localparam int BRK_EXP = 0;
`endif

  uart_rx_ctrl dut (
    .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .Prescale(Prescale),
    .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .STOP2(STOP2),
    .P_DATA(P_DATA), .data_valid(data_valid), .par_err(par_err),
    .stp_err(stp_err), .brk_det(brk_det)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;
  always @(negedge CLK) begin
    if (data_valid) begin
      if (dv_cnt < 4) begin
        dv_cyc[dv_cnt] = cyc;
        dv_data[dv_cnt] = P_DATA;
      end
      dv_cnt++;
    end
    if (brk_det) brk_cnt++;
  end

  task automatic clear();
    dv_cnt = 0;
    brk_cnt = 0;
  endtask

  task automatic idle(input int n);
    RX_IN = 1'b1;
    repeat (n) @(negedge CLK);
  endtask

  task automatic send_bit(input logic b);
    RX_IN = b;
    repeat (Prescale) @(negedge CLK);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pe, input logic pb,
                            input logic s1, input logic s2en, input logic s2);
    start_cyc = cyc + 1;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    if (pe) send_bit(pb);
    send_bit(s1);
    if (s2en) send_bit(s2);
    RX_IN = 1'b1;
  endtask

  task automatic test_reset();
    RST = 1'b0;
    RX_IN = 1'b1;
    repeat (3) @(negedge CLK);
    tests++; if (P_DATA !== 8'h00) begin fails++; $display("FAIL reset_pdata: got %h want 00", P_DATA); end
    tests++; if (data_valid !== 1'b0) begin fails++; $display("FAIL reset_dv: got %b want 0", data_valid); end
    tests++; if (par_err !== 1'b0) begin fails++; $display("FAIL reset_par_err: got %b want 0", par_err); end
    tests++; if (stp_err !== 1'b0) begin fails++; $display("FAIL reset_stp_err: got %b want 0", stp_err); end
    tests++; if (brk_det !== 1'b0) begin fails++; $display("FAIL reset_brk: got %b want 0", brk_det); end
    RST = 1'b1;
    idle(4);
  endtask

  task automatic test_basic();
    Prescale = 6'd8; PAR_EN = 1'b0; STOP2 = 1'b0;
    clear();
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    idle(6);
    tests++; if (dv_cnt !== 1) begin fails++; $display("FAIL basic_dv_count: got %0d want 1", dv_cnt); end
    tests++; if (dv_cyc[0] - start_cyc !== 81) begin fails++; $display("FAIL basic_latency: got %0d want 81", dv_cyc[0] - start_cyc); end
    tests++; if (P_DATA !== 8'hA5) begin fails++; $display("FAIL basic_pdata: got %h want a5", P_DATA); end
    tests++; if (par_err !== 1'b0) begin fails++; $display("FAIL basic_par_err: got %b want 0", par_err); end
    tests++; if (stp_err !== 1'b0) begin fails++; $display("FAIL basic_stp_err: got %b want 0", stp_err); end
  endtask

  task automatic test_parity();
    PAR_EN = 1'b1; PAR_TYP = 1'b1;
    clear();
    send_frame(8'h3C, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    idle(6);
    tests++; if (dv_cnt !== 1) begin fails++; $display("FAIL par_good_dv: got %0d want 1", dv_cnt); end
    tests++; if (P_DATA !== 8'h3C) begin fails++; $display("FAIL par_good_pdata: got %h want 3c", P_DATA); end
    tests++; if (par_err !== 1'b0) begin fails++; $display("FAIL par_good_err: got %b want 0", par_err); end
    clear();
    send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    idle(6);
    tests++; if (dv_cnt !== 0) begin fails++; $display("FAIL par_bad_dv: got %0d want 0", dv_cnt); end
    tests++; if (par_err !== 1'b1) begin fails++; $display("FAIL par_bad_err: got %b want 1", par_err); end
    tests++; if (P_DATA !== 8'h3C) begin fails++; $display("FAIL par_bad_pdata: got %h want 3c", P_DATA); end
    tests++; if (stp_err !== 1'b0) begin fails++; $display("FAIL par_bad_stp: got %b want 0", stp_err); end
    PAR_EN = 1'b0; PAR_TYP = 1'b0;
  endtask

  task automatic test_glitch();
    Prescale = 6'd16;
    clear();
    RX_IN = 1'b0;
    repeat (3) @(negedge CLK);
    idle(30);
    tests++; if (dv_cnt !== 0) begin fails++; $display("FAIL glitch_dv: got %0d want 0", dv_cnt); end
    tests++; if (P_DATA !== 8'h3C) begin fails++; $display("FAIL glitch_pdata: got %h want 3c", P_DATA); end
    tests++; if (par_err !== 1'b1) begin fails++; $display("FAIL glitch_par_hold: got %b want 1", par_err); end
    clear();
    send_frame(8'hC3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    idle(6);
    tests++; if (dv_cnt !== 1) begin fails++; $display("FAIL glitch_next_dv: got %0d want 1", dv_cnt); end
    tests++; if (dv_cyc[0] - start_cyc !== 161) begin fails++; $display("FAIL glitch_next_latency: got %0d want 161", dv_cyc[0] - start_cyc); end
    tests++; if (P_DATA !== 8'hC3) begin fails++; $display("FAIL glitch_next_pdata: got %h want c3", P_DATA); end
    tests++; if (par_err !== 1'b0) begin fails++; $display("FAIL glitch_next_par: got %b want 0", par_err); end
  endtask

  task automatic test_stop2();
    Prescale = 6'd8; STOP2 = 1'b1;
    clear();
    send_frame(8'h81, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(6);
    tests++; if (dv_cnt !== 0) begin fails++; $display("FAIL stop2_bad_dv: got %0d want 0", dv_cnt); end
    tests++; if (stp_err !== 1'b1) begin fails++; $display("FAIL stop2_bad_err: got %b want 1", stp_err); end
    tests++; if (P_DATA !== 8'hC3) begin fails++; $display("FAIL stop2_bad_pdata: got %h want c3", P_DATA); end
    clear();
    send_frame(8'h55, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    idle(6);
    tests++; if (dv_cnt !== 1) begin fails++; $display("FAIL stop2_good_dv: got %0d want 1", dv_cnt); end
    tests++; if (dv_cyc[0] - start_cyc !== 89) begin fails++; $display("FAIL stop2_good_latency: got %0d want 89", dv_cyc[0] - start_cyc); end
    tests++; if (P_DATA !== 8'h55) begin fails++; $display("FAIL stop2_good_pdata: got %h want 55", P_DATA); end
    tests++; if (stp_err !== 1'b0) begin fails++; $display("FAIL stop2_good_err: got %b want 0", stp_err); end
    STOP2 = 1'b0;
  endtask

  task automatic test_back_to_back();
    Prescale = 6'd8;
    clear();
    send_frame(8'h01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    send_frame(8'hFE, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    idle(6);
    tests++; if (dv_cnt !== 2) begin fails++; $display("FAIL b2b_dv_count: got %0d want 2", dv_cnt); end
    tests++; if (dv_data[0] !== 8'h01) begin fails++; $display("FAIL b2b_first: got %h want 01", dv_data[0]); end
    tests++; if (dv_data[1] !== 8'hFE) begin fails++; $display("FAIL b2b_second: got %h want fe", dv_data[1]); end
    tests++; if (dv_cyc[1] - dv_cyc[0] !== 80) begin fails++; $display("FAIL b2b_spacing: got %0d want 80", dv_cyc[1] - dv_cyc[0]); end
  endtask

  task automatic test_break();
    Prescale = 6'd8;
    clear();
    RX_IN = 1'b0;
    repeat (120) @(negedge CLK);
    tests++; if (brk_cnt !== BRK_EXP) begin fails++; $display("FAIL break_mid_pulses: got %0d want %0d", brk_cnt, BRK_EXP); end
    repeat (40) @(negedge CLK);
    idle(20);
    tests++; if (dv_cnt !== 0) begin fails++; $display("FAIL break_dv: got %0d want 0", dv_cnt); end
    tests++; if (stp_err !== 1'b1) begin fails++; $display("FAIL break_stp_err: got %b want 1", stp_err); end
    tests++; if (brk_cnt !== BRK_EXP) begin fails++; $display("FAIL break_pulses: got %0d want %0d", brk_cnt, BRK_EXP); end
    tests++; if (P_DATA !== 8'hFE) begin fails++; $display("FAIL break_pdata: got %h want fe", P_DATA); end
    clear();
    send_frame(8'h3A, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    idle(6);
    tests++; if (dv_cnt !== 1) begin fails++; $display("FAIL break_after_dv: got %0d want 1", dv_cnt); end
    tests++; if (P_DATA !== 8'h3A) begin fails++; $display("FAIL break_after_pdata: got %h want 3a", P_DATA); end
    tests++; if (stp_err !== 1'b0) begin fails++; $display("FAIL break_after_stp: got %b want 0", stp_err); end
  endtask

  task automatic test_mid_reset();
    Prescale = 6'd8;
    clear();
    RX_IN = 1'b0;
    repeat (20) @(negedge CLK);
    #2 RST = 1'b0;
    #1;
    tests++; if (P_DATA !== 8'h00) begin fails++; $display("FAIL midrst_pdata: got %h want 00", P_DATA); end
    tests++; if (data_valid !== 1'b0) begin fails++; $display("FAIL midrst_dv: got %b want 0", data_valid); end
    RX_IN = 1'b1;
    @(negedge CLK);
    RST = 1'b1;
    idle(100);
    tests++; if (dv_cnt !== 0) begin fails++; $display("FAIL midrst_idle_dv: got %0d want 0", dv_cnt); end
    send_frame(8'h96, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    idle(6);
    tests++; if (dv_cnt !== 1) begin fails++; $display("FAIL midrst_next_dv: got %0d want 1", dv_cnt); end
    tests++; if (P_DATA !== 8'h96) begin fails++; $display("FAIL midrst_next_pdata: got %h want 96", P_DATA); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_glitch();
    test_stop2();
    test_back_to_back();
    test_break();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
